// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Arbitrates one byte-wide single-port RAM between the instruction-fetch (IF)
// stage and the MEM stage. Each granted request is sequenced as 1, 2 or 4
// single-byte RAM accesses. Words are assembled and split little-endian: the
// byte at the base address lands in bits [7:0].
//
// Handshake (both requesters): the requester raises *_req and holds its
// address/controls stable until the matching *_done pulse. *_done is a
// one-cycle pulse. Read data (if_data / mem_rdata) is valid in that cycle and
// holds its value until the next pulse on the same port. Requests are only
// arbitrated in IDLE, and MEM wins over IF. A MEM transfer always runs to
// completion once granted. An IF fetch is abandoned if if_req drops while it
// is reading, which lets the pipeline flush a fetch on a taken branch.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-low reset
//   if_req     in   1       fetch request
//   if_addr    in   32      fetch byte address
//   if_done    out  1       fetch complete pulse, if_data valid
//   if_data    out  32      fetched instruction word
//   mem_req    in   1       MEM request
//   mem_we     in   1       1 = store, 0 = load
//   mem_addr   in   32      MEM base byte address
//   mem_len    in   2       0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   mem_wdata  in   32      store data, byte i in bits [8i+7:8i]
//   mem_done   out  1       MEM complete pulse
//   mem_rdata  out  32      load data, zero-extended
//   ram_addr   out  RAM_AW  RAM byte address (holds when idle)
//   ram_we     out  1       RAM write strobe
//   ram_wdata  out  8       RAM write byte
//   ram_rdata  in   8       RAM read byte, one cycle after its address
//   fsm_state  out  3       current controller state (debug view)
//
// Optional build macro
//   IF_LAST_HIT_EN : adds a one-entry {valid, addr, word} record of the last
//                    completed fetch. A fetch that matches it, with no MEM
//                    request in the same cycle, completes in one cycle with
//                    no RAM access. Any granted store, an IF abort or a reset
//                    invalidates the entry.
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_LAST = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Transfer context, latched at grant
    state_t      state;
    logic        owner_if;    // 1 = transfer belongs to IF
    logic [31:0] base;        // base byte address
    logic [31:0] wbuf;        // store data
    logic [1:0]  last_idx;    // index of the final byte (N-1)
    logic [1:0]  idx;         // index of the byte currently addressed/written
    logic [31:0] asm_word;    // read assembly register

    // Combinational helpers
    logic [1:0]        req_last;
    logic [31:0]       next_sum;
    logic [RAM_AW-1:0] next_addr;
    logic [1:0]        cap_idx;
    logic [31:0]       cap_word;
    logic              abort;
    logic              hit_now;
    logic [31:0]       hit_data;
    logic              unused_sum_hi;

    assign fsm_state = state;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        b = w[7:0];
        case (i)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            2'd3: b = w[31:24];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Byte count encoded as the index of the last byte
    always_comb begin
        req_last = 2'd3;
        case (mem_len)
            2'd0:    req_last = 2'd0;
            2'd1:    req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

    // Address of the next byte: full 32-bit wrap first, then truncation to
    // the RAM width. The discarded high bits are folded into an unused net.
    assign next_sum      = base + {30'd0, idx} + 32'd1;
    assign next_addr     = next_sum[RAM_AW-1:0];
    assign unused_sum_hi = ^next_sum[31:RAM_AW];

    // RAM data lags its address by one cycle, so in RD the byte arriving now
    // belongs to idx-1; in RD_LAST it is the final byte.
    always_comb begin
        cap_idx  = (state == ST_RD_LAST) ? last_idx : (idx - 2'd1);
        cap_word = asm_word;
        case (cap_idx)
            2'd0:    cap_word[7:0]   = ram_rdata;
            2'd1:    cap_word[15:8]  = ram_rdata;
            2'd2:    cap_word[23:16] = ram_rdata;
            2'd3:    cap_word[31:24] = ram_rdata;
            default: cap_word        = asm_word;
        endcase
    end

    // Fetch withdrawn while still reading: drop it without a done pulse
    assign abort = owner_if && !if_req && ((state == ST_RD) || (state == ST_RD_LAST));

`ifdef IF_LAST_HIT_EN
    logic        hit_valid;
    logic [31:0] hit_addr;
    logic [31:0] hit_word;
    logic        store_grant;
    logic        fetch_fill;

    assign store_grant = (state == ST_IDLE) && mem_req && mem_we;
    assign fetch_fill  = (state == ST_RD_LAST) && owner_if && if_req;
    assign hit_now     = hit_valid && (if_addr == hit_addr);
    assign hit_data    = hit_word;

    // A store may alias the recorded word, so any granted store invalidates
    // the entry without comparing addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_valid <= 1'b0;
            hit_addr  <= '0;
            hit_word  <= '0;
        end else if (store_grant || abort) begin
            hit_valid <= 1'b0;
        end else if (fetch_fill) begin
            hit_valid <= 1'b1;
            hit_addr  <= base;
            hit_word  <= cap_word;
        end
    end
`else
    assign hit_now  = 1'b0;
    assign hit_data = 32'd0;
`endif

    // Main controller. All outputs are registered here; done and ram_we
    // default low each cycle so they only pulse where explicitly set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner_if  <= 1'b0;
            base      <= '0;
            wbuf      <= '0;
            last_idx  <= '0;
            idx       <= '0;
            asm_word  <= '0;
            if_done   <= 1'b0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        owner_if <= 1'b0;
                        base     <= mem_addr;
                        wbuf     <= mem_wdata;
                        last_idx <= req_last;
                        idx      <= 2'd0;
                        asm_word <= '0;
                        ram_addr <= mem_addr[RAM_AW-1:0];
                        if (mem_we) begin
                            // First byte goes out in the very next cycle
                            ram_we    <= 1'b1;
                            ram_wdata <= mem_wdata[7:0];
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end else if (if_req) begin
                        if (hit_now) begin
                            if_done <= 1'b1;
                            if_data <= hit_data;
                            state   <= ST_DONE;
                        end else begin
                            owner_if <= 1'b1;
                            base     <= if_addr;
                            last_idx <= 2'd3;
                            idx      <= 2'd0;
                            asm_word <= '0;
                            ram_addr <= if_addr[RAM_AW-1:0];
                            state    <= ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        if (idx != 2'd0) begin
                            asm_word <= cap_word;
                        end
                        if (idx == last_idx) begin
                            state <= ST_RD_LAST;
                        end else begin
                            idx      <= idx + 2'd1;
                            ram_addr <= next_addr;
                        end
                    end
                end

                ST_RD_LAST: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        asm_word <= cap_word;
                        if (owner_if) begin
                            if_done <= 1'b1;
                            if_data <= cap_word;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= cap_word;
                        end
                        state <= ST_DONE;
                    end
                end

                ST_WR: begin
                    if (idx == last_idx) begin
                        mem_done <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        idx       <= idx + 2'd1;
                        ram_we    <= 1'b1;
                        ram_addr  <= next_addr;
                        ram_wdata <= byte_of(wbuf, idx + 2'd1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
